// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Two-requester APB master. A round-robin arbiter picks one pending command,
//   runs a single APB transfer (SETUP, then ACCESS until Pready), and returns
//   the completion to the requester that won. A transfer that waits too long
//   for Pready is aborted with an error response.
//
// Ports
//   Pclk, Prst          clock, synchronous active-low reset
//   reqN_valid/write/addr/wdata   command from requester N (held until reqN_ready)
//   reqN_ready          1-cycle pulse: command accepted
//   respN_valid         1-cycle pulse: transfer finished
//   respN_rdata/err     result, held between responses
//   Pselx..Pwdata       APB master outputs
//   Pready/Pslverr/Prdata  APB slave inputs
module apb_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              Pclk,
  input  logic              Prst,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_rdata,
  output logic              resp0_err,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_rdata,
  output logic              resp1_err,
  output logic              Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  input  logic              Pready,
  input  logic              Pslverr,
  input  logic [DATA_W-1:0] Prdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic             last_grant;
  logic             gnt;        // requester owning the transfer in flight
  logic [CNT_W-1:0] cnt;
  logic             pick;       // requester that wins if anyone is valid
  logic             done;       // ACCESS ends this cycle (ready or timeout)
  logic [DATA_W-1:0] done_rdata;
  logic             done_err;

  // Under contention the requester that did not win last time goes next.
  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid) pick = ~last_grant;
    else if (req1_valid)          pick = 1'b1;
  end

  // Pready beats the timeout when both land in the same cycle.
  always_comb begin
    done       = Pready || (cnt == CNT_LAST);
    done_rdata = (Pready && !Pwrite) ? Prdata : '0;
    done_err   = Pready ? Pslverr : 1'b1;
  end

  always_ff @(posedge Pclk) begin
    if (!Prst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      gnt         <= 1'b0;
      cnt         <= '0;
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      resp0_valid <= 1'b0;
      resp0_rdata <= '0;
      resp0_err   <= 1'b0;
      resp1_valid <= 1'b0;
      resp1_rdata <= '0;
      resp1_err   <= 1'b0;
      Pselx       <= 1'b0;
      Penable     <= 1'b0;
      Pwrite      <= 1'b0;
      Paddr       <= '0;
      Pwdata      <= '0;
    end else begin
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt        <= pick;
            last_grant <= pick;
            req0_ready <= ~pick;
            req1_ready <= pick;
            Pwrite     <= pick ? req1_write : req0_write;
            Paddr      <= pick ? req1_addr  : req0_addr;
            Pwdata     <= pick ? req1_wdata : req0_wdata;
            Pselx      <= 1'b1;
            Penable    <= 1'b0;
            state      <= SETUP;
          end
        end
        SETUP: begin
          Penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            if (gnt) begin
              resp1_valid <= 1'b1;
              resp1_rdata <= done_rdata;
              resp1_err   <= done_err;
            end else begin
              resp0_valid <= 1'b1;
              resp0_rdata <= done_rdata;
              resp0_err   <= done_err;
            end
            Pselx   <= 1'b0;
            Penable <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed steps, APB slave model with a memory,
// and a response scoreboard that is filled when commands are issued.
module tb_apb_req_arbiter;

  logic        Pclk, Prst;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic        Pselx, Penable, Pwrite, Pready, Pslverr;
  logic [31:0] Paddr, Pwdata, Prdata;

  apb_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .Pclk(Pclk), .Prst(Prst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
    .Pready(Pready), .Pslverr(Pslverr), .Prdata(Prdata)
  );

  typedef struct {
    bit          port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  bit          grant_q[$];
  int          gcyc[$];
  logic [31:0] mem [logic [31:0]];
  int checks = 0, errors = 0;
  int cyc = 0, acc_len = 0, last_len = 0, acc_cnt = 0;
  int slv_wait = 0;
  bit slv_err = 0, slv_hang = 0;
  logic [31:0] cap_addr = '0;

  initial begin
    Pclk = 1'b0;
    forever #5 Pclk = ~Pclk;
  end

  always @(posedge Pclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void expect_resp(input bit p, input logic e, input logic [31:0] d);
    exp_t x;
    x.port = p; x.err = e; x.rdata = d;
    sb.push_back(x);
  endfunction

  // APB slave: Pready after slv_wait ACCESS cycles, never when slv_hang.
  // Prdata carries visible garbage on writes so a leaked value shows up.
  initial begin
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    forever begin
      @(negedge Pclk);
      if (Pselx && Penable) begin
        Prdata = Pwrite ? 32'hBADC_0DE0 : (mem.exists(Paddr) ? mem[Paddr] : 32'h0);
        if (!slv_hang && acc_cnt >= slv_wait) begin
          Pready = 1'b1; Pslverr = slv_err;
          if (Pwrite && !slv_err) mem[Paddr] = Pwdata;
        end else begin
          Pready = 1'b0; Pslverr = 1'b0;
        end
        acc_cnt++;
      end else begin
        Pready = 1'b0; Pslverr = 1'b0; acc_cnt = 0;
      end
    end
  end

  // Monitor: grant log, response scoreboard, ACCESS length, address stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge Pclk);
      if (req0_ready || req1_ready) begin
        chk("ready_onehot", 64'(req0_ready && req1_ready), 64'd0);
        grant_q.push_back(req1_ready);
        gcyc.push_back(cyc);
      end
      if (resp0_valid || resp1_valid) begin
        chk("resp_onehot", 64'(resp0_valid && resp1_valid), 64'd0);
        checks++;
        assert (sb.size() > 0) else begin
          errors++;
          $error("FAIL resp_unexpected: observed response on port %0d expected none", resp1_valid);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("resp_port",  64'(resp1_valid), 64'(e.port));
          chk("resp_err",   64'(resp1_valid ? resp1_err : resp0_err), 64'(e.err));
          chk("resp_rdata", 64'(resp1_valid ? resp1_rdata : resp0_rdata), 64'(e.rdata));
        end
      end
      if (Pselx && !Penable) cap_addr = Paddr;
      if (Pselx && Penable) begin
        acc_len++;
        chk("paddr_stable", 64'(Paddr), 64'(cap_addr));
      end else if (acc_len != 0) begin
        last_len = acc_len;
        acc_len  = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic issue(input bit p, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    if (!p) begin req0_valid = 1; req0_write = wr; req0_addr = a; req0_wdata = d; end
    else    begin req1_valid = 1; req1_write = wr; req1_addr = a; req1_wdata = d; end
    do begin @(negedge Pclk); n++; end while (!(p ? req1_ready : req0_ready) && n < 50);
    chk("grant_seen", 64'(p ? req1_ready : req0_ready), 64'd1);
    if (!p) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge Pclk); n++; end
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
    @(negedge Pclk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_apb"},   {29'd0, Pselx, Penable, Pwrite, Paddr}, 64'd0);
    chk({tag, "_wdata"}, 64'(Pwdata), 64'd0);
    chk({tag, "_hs"},    64'({req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err}), 64'd0);
    chk({tag, "_rdata"}, {resp0_rdata, resp1_rdata}, 64'd0);
  endtask

  initial begin
    int n, got;
    Prst = 0;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    repeat (3) @(negedge Pclk);
    chk_all_zero("reset");

    // 1: single write, zero-wait slave, cycle by cycle
    Prst = 1;
    expect_resp(0, 0, 32'h0);
    req0_valid = 1; req0_write = 1; req0_addr = 32'h04; req0_wdata = 32'hDEADBEEF;
    @(negedge Pclk);
    chk("t1_ready", 64'({req0_ready, req1_ready}), 64'b10);
    chk("t1_setup", 64'({Pselx, Penable, Pwrite}), 64'b101);
    chk("t1_paddr", 64'(Paddr), 64'h04);
    chk("t1_pwdata", 64'(Pwdata), 64'hDEADBEEF);
    req0_valid = 0;
    @(negedge Pclk);
    chk("t1_access", 64'({req0_ready, Pselx, Penable}), 64'b011);
    @(negedge Pclk);
    chk("t1_resp", 64'({resp0_valid, resp0_err, Pselx, Penable}), 64'b1000);
    @(negedge Pclk);

    // 2: read back through req1 with two wait states
    slv_wait = 2;
    expect_resp(1, 0, 32'hDEADBEEF);
    issue(1, 0, 32'h04, 32'h0);
    wait_idle("t2");
    chk("t2_access_len", 64'(last_len), 64'd3);
    slv_wait = 0;

    // 3: continuous contention after reset, round-robin starting at req0
    Prst = 0;
    repeat (2) @(negedge Pclk);
    Prst = 1;
    grant_q.delete(); gcyc.delete();
    expect_resp(0, 0, 32'h0); expect_resp(1, 0, 32'h0);
    expect_resp(0, 0, 32'h0); expect_resp(1, 0, 32'h0);
    req0_valid = 1; req0_write = 1; req0_addr = 32'h10; req0_wdata = 32'h1000_0000;
    req1_valid = 1; req1_write = 1; req1_addr = 32'h20; req1_wdata = 32'h2000_0000;
    n = 0; got = 0;
    while (got < 4 && n < 100) begin
      @(negedge Pclk); n++;
      if (req0_ready) begin got++; req0_addr += 4; req0_wdata += 1; end
      if (req1_ready) begin got++; req1_addr += 4; req1_wdata += 1; end
      if (got >= 4) begin req0_valid = 0; req1_valid = 0; end
    end
    req0_valid = 0; req1_valid = 0;
    wait_idle("t3");
    chk("t3_ngrant", 64'(grant_q.size()), 64'd4);
    if (grant_q.size() >= 4)
      for (int k = 0; k < 4; k++) begin
        chk("t3_order", 64'(grant_q[k]), 64'(k % 2));
        if (k > 0) chk("t3_spacing", 64'(gcyc[k] - gcyc[k-1]), 64'd3);
      end

    // 4: slave error on a read, data still returned
    slv_err = 1;
    expect_resp(0, 1, 32'hDEADBEEF);
    issue(0, 0, 32'h04, 32'h0);
    wait_idle("t4");
    slv_err = 0;

    // 5: hung slave times out after 16 ACCESS cycles, then normal traffic
    slv_hang = 1;
    expect_resp(1, 1, 32'h0);
    issue(1, 0, 32'h04, 32'h0);
    wait_idle("t5");
    chk("t5_access_len", 64'(last_len), 64'd16);
    slv_hang = 0;
    expect_resp(0, 0, 32'hDEADBEEF);
    issue(0, 0, 32'h04, 32'h0);
    wait_idle("t5b");

    // 6: reset during ACCESS drops the transfer; req0 wins afterwards
    slv_hang = 1;
    issue(0, 0, 32'h04, 32'h0);
    n = 0;
    do begin @(negedge Pclk); n++; end while (!Penable && n < 10);
    chk("t6_in_access", 64'({Pselx, Penable}), 64'b11);
    Prst = 0;
    req0_valid = 1; req0_write = 0; req0_addr = 32'h04; req0_wdata = 0;
    req1_valid = 1; req1_write = 0; req1_addr = 32'h10; req1_wdata = 0;
    @(negedge Pclk);
    chk_all_zero("t6_reset");
    slv_hang = 0;
    Prst = 1;
    expect_resp(0, 0, 32'hDEADBEEF);
    expect_resp(1, 0, 32'h1000_0000);
    @(negedge Pclk);
    chk("t6_first_grant", 64'({req0_ready, req1_ready}), 64'b10);
    req0_valid = 0;
    n = 0;
    while (!req1_ready && n < 20) begin @(negedge Pclk); n++; end
    chk("t6_second_grant", 64'(req1_ready), 64'd1);
    req1_valid = 0;
    wait_idle("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
